// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} fetch_state_t;
    localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: imem request/response, redirect input, decode handshake.
interface fetch_if #(
    parameter int DATA_WIDTH = 32
);
    import fetch_pkg::*;

    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [DATA_WIDTH-1:0] imem_req_addr;
    logic                  imem_rsp_valid;
    logic [DATA_WIDTH-1:0] imem_rsp_data;
    logic                  redirect;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic [DATA_WIDTH-1:0] redirect_imm;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] instr_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect, redirect_pc, redirect_imm,
        output instr_valid, instr, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect, redirect_pc, redirect_imm,
        input  instr_valid, instr, instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; used for the instruction buffer
// and for the in-flight request-PC queue.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, credit-limited imem requests, instruction
// buffer and redirect handling with discard of wrong-path responses.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input logic       clk,
    input logic       rst,
    fetch_if.master   bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int QW = 2 * DATA_WIDTH;

    fetch_state_t          state;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] req_pc;
    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] target;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         discard;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         out_after_rsp;
    logic [QW-1:0]         fifo_dout;
    logic                  active;
    logic                  redir;
    logic                  accept;
    logic                  rsp;
    logic                  drop;
    logic                  push;
    logic                  pop;

    assign active = (state != IDLE);
    assign redir  = active && bus.redirect;
    assign rsp    = bus.imem_rsp_valid;
    assign drop   = (discard != '0);

    assign bus.imem_req_valid = active && !bus.redirect &&
                                ((outstanding + fifo_count) < CW'(FIFO_DEPTH));
    assign bus.imem_req_addr  = pc;
    assign accept = bus.imem_req_valid && bus.imem_req_ready;

    assign push = rsp && !drop && !redir;
    assign pop  = bus.instr_valid && bus.instr_ready && !redir;

    assign out_after_rsp = outstanding - CW'(rsp);
    assign sum    = bus.redirect_pc + bus.redirect_imm;
    assign target = {sum[DATA_WIDTH-1:2], 2'b00};

    // Occupancy of the request-PC queue is the outstanding count.
    fetch_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_pcq (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (rsp),
        .flush (1'b0),
        .din   (pc),
        .dout  (req_pc),
        .count (outstanding)
    );

    fetch_fifo #(.WIDTH(QW), .DEPTH(FIFO_DEPTH)) u_ibuf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redir),
        .din   ({bus.imem_rsp_data, req_pc}),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign bus.instr_valid = (fifo_count != '0);
    assign bus.instr    = bus.instr_valid ? fifo_dout[QW-1:DATA_WIDTH] : '0;
    assign bus.instr_pc = bus.instr_valid ? fifo_dout[DATA_WIDTH-1:0]  : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            discard <= '0;
        end else begin
            unique case (state)
                IDLE: state <= RUN;
                RUN, DRAIN: begin
                    if (redir) begin
                        pc      <= target;
                        discard <= out_after_rsp;
                        state   <= (out_after_rsp != '0) ? DRAIN : RUN;
                    end else begin
                        if (accept) pc <= pc + DATA_WIDTH'(INSTR_BYTES);
                        if (rsp && drop) begin
                            discard <= discard - CW'(1);
                            if (discard == CW'(1)) state <= RUN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with a latency-varying imem model.
module tb_fetch_unit;
    localparam int          DW       = 32;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_if #(.DATA_WIDTH(DW)) bus ();

    fetch_unit #(
        .DATA_WIDTH (DW),
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors   = 0;
    int errors    = 0;
    int delivered = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    // Reference stream: after reset or redirect, PCs run target, target+4, ...
    logic [31:0] exp_q[$];
    logic [31:0] model_pc;

    function automatic void restart(logic [31:0] p);
        exp_q.delete();
        model_pc = p;
    endfunction

    // Instruction memory: in-order responses, latency lat_min..lat_max.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        memq[$];
    int          cyc       = 0;
    int          last_due  = 0;
    int          lat_min   = 1;
    int          lat_max   = 1;
    int          ready_pct = 100;
    logic        acc_s     = 1'b0;
    logic [31:0] acc_addr  = '0;

    always @(negedge clk) begin
        acc_s    = bus.imem_req_valid && bus.imem_req_ready;
        acc_addr = bus.imem_req_addr;
    end

    always @(posedge clk) begin
        int   due;
        req_t r;
        #1;
        cyc++;
        if (rst) begin
            memq.delete();
            last_due = cyc;
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end else begin
            if (acc_s) begin
                due = cyc + $urandom_range(lat_max, lat_min) - 1;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                r.addr = acc_addr;
                r.due  = due;
                memq.push_back(r);
            end
            if (memq.size() > 0 && memq[0].due <= cyc) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_word(memq[0].addr);
                void'(memq.pop_front());
            end else begin
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = $urandom;
            end
        end
        bus.imem_req_ready = ($urandom_range(99, 0) < ready_pct);
    end

    // Monitor: pops the scoreboard on every accepted decode transfer.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst) begin
            check("outstanding_le_depth",
                  32'((memq.size() + int'(bus.imem_rsp_valid)) <= DEPTH), 32'd1);
            if (bus.instr_valid && bus.instr_ready && !bus.redirect) begin
                while (exp_q.size() < 4) begin
                    exp_q.push_back(model_pc);
                    model_pc += 32'd4;
                end
                e = exp_q.pop_front();
                check("instr_pc", bus.instr_pc, e);
                check("instr", bus.instr, mem_word(e));
                delivered++;
            end
        end
    end

    task automatic do_redirect(logic [31:0] rpc, logic [31:0] imm);
        logic [31:0] s;
        s = rpc + imm;
        bus.redirect     = 1'b1;
        bus.redirect_pc  = rpc;
        bus.redirect_imm = imm;
        restart({s[31:2], 2'b00});
    endtask

    task automatic check_zero_outputs(string tag);
        check({tag, "_req_valid"},   32'(bus.imem_req_valid), 32'd0);
        check({tag, "_req_addr"},    bus.imem_req_addr, RESET_PC);
        check({tag, "_instr_valid"}, 32'(bus.instr_valid), 32'd0);
        check({tag, "_instr"},       bus.instr, 32'd0);
        check({tag, "_instr_pc"},    bus.instr_pc, 32'd0);
    endtask

    initial begin
        logic [31:0] hold_i;
        logic [31:0] hold_pc;
        int          base;
        bit          hit;

        bus.redirect     = 1'b0;
        bus.redirect_pc  = '0;
        bus.redirect_imm = '0;
        bus.instr_ready  = 1'b0;
        restart(RESET_PC);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");

        // Straight-line fetch, 1-cycle memory.
        @(posedge clk); #2;
        rst = 1'b0;
        bus.instr_ready = 1'b1;
        repeat (40) @(posedge clk);
        check("fill_progress", 32'(delivered >= 15), 32'd1);

        // Decode stall: buffer fills, requests stop, outputs hold.
        #2 bus.instr_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        hold_i  = bus.instr;
        hold_pc = bus.instr_pc;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(bus.instr_valid), 32'd1);
            check("stall_instr", bus.instr, hold_i);
            check("stall_pc", bus.instr_pc, hold_pc);
            check("stall_no_req", 32'(bus.imem_req_valid), 32'd0);
        end
        @(posedge clk); #2;
        bus.instr_ready = 1'b1;
        base = delivered;
        repeat (20) @(posedge clk);
        check("resume_progress", 32'(delivered > base + 5), 32'd1);

        // Redirect with two requests in flight, 3-cycle memory.
        lat_min = 3;
        lat_max = 3;
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(posedge clk); #2;
            if (memq.size() + int'(bus.imem_rsp_valid) == 2) hit = 1'b1;
        end
        check("drain_setup", 32'(hit), 32'd1);
        do_redirect(32'h10, 32'h20);
        @(posedge clk); #2;
        bus.redirect = 1'b0;
        @(negedge clk);
        check("drain_flushed", 32'(bus.instr_valid), 32'd0);
        base = delivered;
        repeat (30) @(posedge clk);
        check("drain_progress", 32'(delivered > base), 32'd1);

        // Redirect coinciding with a response and a pop; negative offset.
        lat_min = 1;
        lat_max = 1;
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(posedge clk); #2;
            if (bus.imem_rsp_valid && bus.instr_valid) hit = 1'b1;
        end
        check("coincide_setup", 32'(hit), 32'd1);
        do_redirect(32'h8, 32'hffff_fff8);
        @(posedge clk); #2;
        bus.redirect = 1'b0;
        @(negedge clk);
        check("coincide_flushed", 32'(bus.instr_valid), 32'd0);
        base = delivered;
        repeat (20) @(posedge clk);
        check("coincide_progress", 32'(delivered > base), 32'd1);

        // Random traffic with random redirects.
        lat_min   = 1;
        lat_max   = 3;
        ready_pct = 50;
        base = delivered;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #2;
            bus.redirect    = 1'b0;
            bus.instr_ready = ($urandom_range(99, 0) < 70);
            if ($urandom_range(39, 0) == 0)
                do_redirect($urandom, $urandom_range(255, 0) - 128);
        end
        @(posedge clk); #2;
        bus.redirect = 1'b0;
        check("random_progress", 32'(delivered > base + 100), 32'd1);

        // Asynchronous reset in the middle of a cycle.
        ready_pct = 100;
        lat_max   = 1;
        bus.instr_ready = 1'b1;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        restart(RESET_PC);
        #1;
        check_zero_outputs("async_rst");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        base = delivered;
        repeat (30) @(posedge clk);
        check("restart_progress", 32'(delivered > base + 10), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
